// File: rtl/tarot_pkg.sv
// Shared constants, FSM state encoding and spread-size clamp for the tarot card drawer.
package tarot_pkg;

    localparam int DECK_SIZE  = 78;
    localparam int MAX_SPREAD = 10;
    localparam int CARD_W     = 7;
    localparam int SLOT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_MAP,
        ST_PROBE,
        ST_EMIT,
        ST_FINISH
    } state_t;

    // An empty request still draws one card; oversize requests are capped at a full cross.
    function automatic logic [SLOT_W-1:0] clamp_spread(input logic [SLOT_W-1:0] n);
        if (n == '0) begin
            return SLOT_W'(1);
        end else if (n > SLOT_W'(MAX_SPREAD)) begin
            return SLOT_W'(MAX_SPREAD);
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/card_range_map.sv
// Scales a 32-bit uniform value onto the deck: top bits of x * DECK_SIZE give 0..DECK_SIZE-1.
module card_range_map
    import tarot_pkg::*;
(
    input  logic [31:0]       rand_x,
    output logic [CARD_W-1:0] card
);

    logic [38:0] product;

    assign product = 39'(rand_x) * 39'(DECK_SIZE);
    assign card    = product[38:32];

endmodule

// File: rtl/tarot_card_drawer.sv
// Draws a spread of distinct tarot cards, one chained PRNG run per card, with linear
// probing past cards already drawn in the current spread.
module tarot_card_drawer
    import tarot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              draw_req,
    input  logic [3:0]        num_cards,
    input  logic [31:0]       seed_in,
    output logic              prng_start,
    output logic [31:0]       prng_seed,
    input  logic              prng_done,
    input  logic [31:0]       random_x,
    input  logic [31:0]       random_y,
    output logic              card_valid,
    output logic [CARD_W-1:0] card_index,
    output logic              card_reversed,
    output logic [SLOT_W-1:0] card_slot,
    output logic              busy,
    output logic              all_done
);

    state_t              state_reg, state_next;
    logic [SLOT_W-1:0]   n_reg, count_reg, count_inc;
    logic [CARD_W-1:0]   cand_reg, cand_wrap, mapped_card;
    logic                rev_reg;
    logic [31:0]         seed_reg;
    logic [DECK_SIZE-1:0] used_reg, cand_onehot;
    logic                accept, cand_used;

    logic                prng_start_next, card_valid_next, all_done_next, busy_next;
    logic                prng_start_reg, card_valid_reg, all_done_reg, busy_reg;
    logic [CARD_W-1:0]   card_index_reg;
    logic                card_reversed_reg;
    logic [SLOT_W-1:0]   card_slot_reg;

    card_range_map u_map (
        .rand_x (random_x),
        .card   (mapped_card)
    );

    assign accept    = (state_reg == ST_IDLE) && draw_req;
    assign cand_used = used_reg[cand_reg];
    assign cand_wrap = (cand_reg == CARD_W'(DECK_SIZE - 1)) ? '0 : cand_reg + CARD_W'(1);
    assign count_inc = count_reg + SLOT_W'(1);

    generate
        for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_onehot
            assign cand_onehot[gi] = (cand_reg == CARD_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (draw_req) state_next = ST_START;
            ST_START:  state_next = ST_WAIT;
            ST_WAIT:   if (prng_done) state_next = ST_MAP;
            ST_MAP:    state_next = ST_PROBE;
            ST_PROBE:  if (!cand_used) state_next = ST_EMIT;
            ST_EMIT:   state_next = (count_inc == n_reg) ? ST_FINISH : ST_START;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is high exactly while its state is current.
    always_comb begin
        prng_start_next = (state_next == ST_START);
        card_valid_next = (state_next == ST_EMIT);
        all_done_next   = (state_next == ST_FINISH);
        busy_next       = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prng_start_reg    <= 1'b0;
            card_valid_reg    <= 1'b0;
            all_done_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            card_index_reg    <= '0;
            card_reversed_reg <= 1'b0;
            card_slot_reg     <= '0;
        end else begin
            prng_start_reg <= prng_start_next;
            card_valid_reg <= card_valid_next;
            all_done_reg   <= all_done_next;
            busy_reg       <= busy_next;
            if (card_valid_next) begin
                card_index_reg    <= cand_reg;
                card_reversed_reg <= rev_reg;
                card_slot_reg     <= count_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg     <= '0;
            count_reg <= '0;
            cand_reg  <= '0;
            rev_reg   <= 1'b0;
            seed_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (draw_req) begin
                        n_reg     <= clamp_spread(num_cards);
                        seed_reg  <= seed_in;
                        count_reg <= '0;
                    end
                end
                ST_MAP: begin
                    cand_reg <= mapped_card;
                    rev_reg  <= random_y[31];
                    seed_reg <= random_x;
                end
                ST_PROBE: begin
                    if (cand_used) cand_reg <= cand_wrap;
                end
                ST_EMIT: begin
                    count_reg <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_reg <= '0;
        end else if (accept) begin
            used_reg <= '0;
        end else if (state_reg == ST_EMIT) begin
            used_reg <= used_reg | cand_onehot;
        end
    end

    assign prng_start    = prng_start_reg;
    assign prng_seed     = seed_reg;
    assign card_valid    = card_valid_reg;
    assign card_index    = card_index_reg;
    assign card_reversed = card_reversed_reg;
    assign card_slot     = card_slot_reg;
    assign busy          = busy_reg;
    assign all_done      = all_done_reg;

endmodule

// File: tb/tb_tarot_card_drawer.sv
// Scoreboard bench: a stub PRNG serves queued values, a deck-level model predicts each spread.
`timescale 1ns/1ps
module tb_tarot_card_drawer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        draw_req = 1'b0;
    logic [3:0]  num_cards = '0;
    logic [31:0] seed_in = '0;
    logic        prng_start;
    logic [31:0] prng_seed;
    logic        prng_done = 1'b0;
    logic [31:0] random_x = '0;
    logic [31:0] random_y = '0;
    logic        card_valid;
    logic [6:0]  card_index;
    logic        card_reversed;
    logic [3:0]  card_slot;
    logic        busy;
    logic        all_done;

    always #5 clk = ~clk;

    tarot_card_drawer dut (
        .clk           (clk),
        .rst           (rst),
        .draw_req      (draw_req),
        .num_cards     (num_cards),
        .seed_in       (seed_in),
        .prng_start    (prng_start),
        .prng_seed     (prng_seed),
        .prng_done     (prng_done),
        .random_x      (random_x),
        .random_y      (random_y),
        .card_valid    (card_valid),
        .card_index    (card_index),
        .card_reversed (card_reversed),
        .card_slot     (card_slot),
        .busy          (busy),
        .all_done      (all_done)
    );

    typedef struct {
        int idx;
        bit rev;
        int slot;
    } card_t;

    card_t       exp_card_q[$];
    logic [31:0] exp_seed_q[$];
    logic [31:0] stub_xq[$];
    logic [31:0] stub_yq[$];
    logic [31:0] fixed_x[10];
    logic [31:0] fixed_y[10];
    card_t       mon_e;
    int checks = 0;
    int failures = 0;
    int cards_seen = 0;
    int done_seen = 0;
    int done_pending = 0;
    bit stub_auto = 1'b1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // Deck position of a uniform 32-bit value: floor(x * 78 / 2^32).
    function automatic int ref_map(input logic [31:0] x);
        logic [63:0] p;
        p = {32'd0, x} * 64'd78;
        return int'(p >> 32);
    endfunction

    // Stub PRNG: answers each start after a random latency with the next queued x/y pair.
    initial begin : stub
        int lat;
        forever begin
            @(negedge clk);
            if (stub_auto && !rst && prng_start) begin
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                if (stub_xq.size() > 0) random_x = stub_xq.pop_front();
                else random_x = $urandom();
                if (stub_yq.size() > 0) random_y = stub_yq.pop_front();
                else random_y = $urandom();
                prng_done = 1'b1;
                @(negedge clk);
                prng_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && card_valid) begin
            cards_seen++;
            $display("card slot=%0d idx=%0d rev=%0d", card_slot, card_index, card_reversed);
            if (exp_card_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL card_unexpected got idx=%0d slot=%0d expected none", card_index, card_slot);
            end else begin
                mon_e = exp_card_q.pop_front();
                chk("card_index", 32'(card_index), mon_e.idx);
                chk("card_reversed", 32'(card_reversed), 32'(mon_e.rev));
                chk("card_slot", 32'(card_slot), mon_e.slot);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && prng_start) begin
            if (exp_seed_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL start_unexpected got seed=%0h expected no start", prng_seed);
            end else begin
                chk("prng_seed", prng_seed, exp_seed_q.pop_front());
            end
            chk("busy_at_start", 32'(busy), 1);
        end
    end

    always @(negedge clk) begin
        if (!rst && all_done) begin
            done_seen++;
            chk("cards_left_at_done", exp_card_q.size(), 0);
            chk("busy_at_done", 32'(busy), 1);
            if (done_pending == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected got all_done=1 expected 0");
            end else begin
                done_pending--;
            end
        end
    end

    task automatic run_spread(input logic [3:0] n_raw, input logic [31:0] seed,
                              input bit fixed, input bit poke_busy);
        int n_eff, c, prev_done;
        bit used[78];
        logic [31:0] x, y, last_x;
        n_eff = (n_raw == 0) ? 1 : ((n_raw > 10) ? 10 : int'(n_raw));
        foreach (used[i]) used[i] = 1'b0;
        exp_seed_q.push_back(seed);
        last_x = $urandom();
        for (int k = 0; k < n_eff; k++) begin
            if (fixed) begin
                x = fixed_x[k];
                y = fixed_y[k];
            end else begin
                x = (k > 0 && $urandom_range(0, 2) == 0) ? last_x : $urandom();
                y = $urandom();
            end
            last_x = x;
            stub_xq.push_back(x);
            stub_yq.push_back(y);
            c = ref_map(x);
            while (used[c]) c = (c + 1) % 78;
            used[c] = 1'b1;
            exp_card_q.push_back('{c, y[31], k});
            if (k < n_eff - 1) exp_seed_q.push_back(x);
        end
        done_pending++;
        prev_done = done_seen;
        $display("draw n=%0d seed=%0h cards=%0d", n_raw, seed, n_eff);
        @(negedge clk);
        num_cards = n_raw;
        seed_in   = seed;
        draw_req  = 1'b1;
        @(negedge clk);
        draw_req  = 1'b0;
        num_cards = 4'($urandom());
        seed_in   = $urandom();
        chk("start_latency", 32'(prng_start), 1);
        if (poke_busy) begin
            repeat (3) @(negedge clk);
            draw_req  = 1'b1;
            num_cards = 4'd1;
            seed_in   = $urandom();
            @(negedge clk);
            draw_req  = 1'b0;
        end
        for (int i = 0; i < 3000 && done_seen == prev_done; i++) @(negedge clk);
        chk("spread_completed", 32'(done_seen != prev_done), 1);
        if (done_seen == prev_done) begin
            exp_card_q.delete();
            exp_seed_q.delete();
            stub_xq.delete();
            stub_yq.delete();
            done_pending = 0;
        end
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_card_valid"}, 32'(card_valid), 0);
        chk({tag, "_card_index"}, 32'(card_index), 0);
        chk({tag, "_card_reversed"}, 32'(card_reversed), 0);
        chk({tag, "_card_slot"}, 32'(card_slot), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_all_done"}, 32'(all_done), 0);
        chk({tag, "_prng_start"}, 32'(prng_start), 0);
        chk({tag, "_prng_seed"}, prng_seed, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int prev_cards;
        logic [31:0] x0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fixed_x[0] = 32'h0000_0000; fixed_x[1] = 32'h8000_0000; fixed_x[2] = 32'hFFFF_FFFF;
        fixed_y[0] = $urandom();    fixed_y[1] = $urandom();    fixed_y[2] = $urandom();
        run_spread(4'd3, 32'h1234_5678, 1'b1, 1'b0);

        fixed_x[0] = 32'hFFFF_FFFF; fixed_x[1] = 32'hFFFF_FFFF; fixed_x[2] = 32'hFFFF_FFFF;
        run_spread(4'd3, 32'h0BAD_F00D, 1'b1, 1'b0);

        fixed_x[0] = $urandom();    fixed_x[1] = $urandom();
        fixed_y[0] = 32'h8000_0000; fixed_y[1] = 32'h7FFF_FFFF;
        run_spread(4'd2, 32'h0012_3456, 1'b1, 1'b0);

        run_spread(4'd0, $urandom(), 1'b0, 1'b0);
        run_spread(4'd15, $urandom(), 1'b0, 1'b0);
        run_spread(4'd5, $urandom(), 1'b0, 1'b1);

        // prng_done while idle must not produce a card.
        stub_auto = 1'b0;
        prev_cards = cards_seen;
        random_x = $urandom();
        random_y = $urandom();
        prng_done = 1'b1;
        @(negedge clk);
        prng_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_done_cards", cards_seen, prev_cards);
        chk("idle_done_busy", 32'(busy), 0);

        // Reset while waiting on the second card's PRNG run.
        x0 = 32'h4000_0000;
        exp_seed_q.push_back(32'hCAFE_0001);
        exp_seed_q.push_back(x0);
        exp_card_q.push_back('{19, 1'b0, 0});
        prev_cards = cards_seen;
        $display("draw n=3 seed=cafe0001 (reset mid-spread)");
        num_cards = 4'd3;
        seed_in   = 32'hCAFE_0001;
        draw_req  = 1'b1;
        @(negedge clk);
        draw_req  = 1'b0;
        for (int i = 0; i < 50 && !prng_start; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        random_x  = x0;
        random_y  = 32'h0000_0000;
        prng_done = 1'b1;
        @(negedge clk);
        prng_done = 1'b0;
        for (int i = 0; i < 50 && cards_seen == prev_cards; i++) @(negedge clk);
        chk("reset_test_first_card", cards_seen, prev_cards + 1);
        for (int i = 0; i < 50 && !prng_start; i++) @(negedge clk);
        chk("reset_test_second_start", 32'(prng_start), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_seeds_left", exp_seed_q.size(), 0);
        prev_cards = cards_seen;
        random_x  = $urandom();
        prng_done = 1'b1;
        @(negedge clk);
        prng_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("late_done_cards", cards_seen, prev_cards);
        chk("late_done_busy", 32'(busy), 0);
        stub_auto = 1'b1;
        run_spread(4'd4, 32'h0F0F_0F0F, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_spread(4'($urandom_range(0, 15)), $urandom(), 1'b0, r[0]);
        end

        repeat (5) @(negedge clk);
        chk("final_cards_left", exp_card_q.size(), 0);
        chk("final_seeds_left", exp_seed_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tarot_card_drawer.md
# tarot_card_drawer

Downstream consumer of `henon_prng_top`: converts its chaotic outputs into a spread of distinct tarot cards. On a draw request it issues one PRNG run per card and maps `random_out_x` to a deck index 0..77. It guarantees no card repeats within a spread. It takes orientation from `random_out_y` and chains seeds between runs, streaming each card out with a one-cycle valid strobe to the display/UART layer.

## Interface
- `DECK_SIZE`, 78, cards in deck; index width is 7 bits.
- `MAX_SPREAD`, 10, maximum cards per draw (Celtic cross).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `draw_req`  in  1  one-cycle pulse; starts a spread when idle.
- `num_cards`  in  4  spread size, sampled on accepted `draw_req`.
- `seed_in`  in  32  Q31 seed for the first PRNG run, sampled with `draw_req`.
- `prng_start`  out  1  one-cycle start pulse to `henon_prng_top.start`.
- `prng_seed`  out  32  drives `henon_prng_top.seed_q31`; held stable from `prng_start` until `prng_done`.
- `prng_done`  in  1  from `henon_prng_top.done`.
- `random_x`, `random_y`  in  32  from `random_out_x` / `random_out_y`.
- `card_valid`  out  1  one-cycle strobe per card.
- `card_index`  out  7  card 0..77, valid with `card_valid`.
- `card_reversed`  out  1  orientation, valid with `card_valid`.
- `card_slot`  out  4  spread position 0..n-1, valid with `card_valid`.
- `busy`  out  1  high from acceptance until the cycle after `all_done`.
- `all_done`  out  1  one-cycle pulse after the last card.

## Operation
- States: IDLE, START, WAIT, MAP, PROBE, EMIT, FINISH.
- **IDLE:**
  - On `draw_req`, latch n and `prng_seed <= seed_in`.
  - Clamp n: 0 becomes 1; values above 10 become 10.
  - Clear the 78-bit used mask and the slot counter, then go to START.
  - `draw_req` in any other state is ignored.
- **START:** assert `prng_start` for one cycle, then go to WAIT.
- **WAIT:** hold until `prng_done`=1, then go to MAP. `prng_done` in any other state is ignored.
- **MAP:**
  - cand <= bits [38:32] of the 39-bit product `random_x` × 78. This is unsigned and always 0..77.
  - rev <= `random_y`[31].
  - `prng_seed <= random_x`, which is the seed for the next card.
  - Go to PROBE.
- **PROBE:**
  - If used[cand]=1, set cand <= (cand==77) ? 0 : cand+1 and stay in PROBE, one probe per cycle.
  - Otherwise go to EMIT.
  - Probing terminates in at most 9 extra cycles, since at most 9 cards are used.
- **EMIT:**
  - Pulse `card_valid` with index=cand, reversed=rev, slot=current count.
  - Set used[cand] and increment the slot counter.
  - If the count reaches n, go to FINISH; otherwise go to START.
- **FINISH:** pulse `all_done`, then go to IDLE.
- **Reset values:**
  - All outputs 0, `prng_seed` 0, state IDLE, used mask cleared.
  - A reset mid-spread aborts it immediately; no further `card_valid` is produced.
  - `prng_done` arriving later is ignored.

## Timing
- `draw_req` at cycle t puts START at t+1, so `prng_start` is high at t+1.
- Per card: 1 (START) + PRNG latency L + 1 (MAP) + (1 + p) (PROBE, p = collisions) + 1 (EMIT).
- `card_valid` for card k is registered and asserted for exactly one cycle.
- `card_index`, `card_reversed` and `card_slot` hold their values until the next EMIT.
- `busy` rises the cycle after accepted `draw_req` and falls the cycle after `all_done`.
- `draw_req` coincident with `all_done` is ignored.

## Structure
- Shared package `tarot_pkg` holds:
  - `DECK_SIZE` and `MAX_SPREAD`;
  - `CARD_W` = 7;
  - the state enum;
  - the clamp function for n.
- One combinational sub-module, `card_range_map`: 32×7 multiply with top-bit extraction, so the bench can unit-test the mapping.
- The used mask is a flat 78-bit register in the top level.

## Test plan
- **Mapping boundaries.** Stub PRNG returns x=0, 0x80000000 and 0xFFFFFFFF with n=3. Cards must be 0, 39, 77, with slots 0, 1, 2.
- **Collision probe.** Stub returns x=0xFFFFFFFF three times with n=3. Cards must be 77, 0, 1 (wrap-around), with `all_done` after the third.
- **Orientation and seed chaining:**
  - `seed_in`=0x00123456 and y=0x80000000 must give reversed=1; y=0x7FFFFFFF must give reversed=0.
  - The second `prng_start` must see `prng_seed` equal to the first card's `random_x`.
- **Clamping.** n=0 must produce exactly one card. n=15 must produce exactly 10 distinct cards.
- **Ignored inputs:**
  - `draw_req` while busy causes no restart.
  - `prng_done` in IDLE causes no `card_valid`.
- **Reset mid-operation.** Assert `rst` during WAIT of card 2:
  - outputs must go to 0 and state to IDLE;
  - a late `prng_done` must produce nothing;
  - a new `draw_req` must then yield a clean spread.
